rr_mux_pipe: RTL and testbench
==============================

RR_MUX_PIPE -- requirements
Module: rr_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter NUM, default 8, channel count (legal 2..16).
REQ-003 SHALL have derived localparam SELW = $clog2(NUM), the index width.
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have mode  input  1  0 = round-robin, 1 = static select.
REQ-007 SHALL have sel  input  SELW  static-mode channel index.
REQ-008 SHALL have in_valid  input  NUM  per-channel valid.
REQ-009 SHALL have in_data  input  NUM x WIDTH  per-channel payload, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have in_ready  output  NUM  per-channel accept, one-hot or zero.
REQ-011 SHALL have out_valid  output  1  output register holds data.
REQ-012 SHALL have out_data  output  WIDTH  registered payload.
REQ-013 SHALL have out_idx  output  SELW  source channel of out_data.
REQ-014 SHALL have out_ready  input  1  downstream accept.

Function
REQ-015 SHALL hold a single output register (out_valid, out_data, out_idx); load enable ld = !out_valid || out_ready.
REQ-016 SHALL raise in_ready[g] only for granted channel g, only when ld=1 and in_valid[g]=1; transfer occurs when in_valid[i] and in_ready[i] are both 1.
REQ-017 SHALL load the output register on the edge after a transfer; latency input-to-out_valid is exactly 1 cycle.
REQ-018 SHALL clear out_valid when out_ready=1 and no transfer occurs in the same cycle; simultaneous drain and transfer SHALL keep out_valid=1 with new data (full throughput, 1 beat/cycle).
REQ-019 SHALL hold out_data and out_idx stable while out_valid=1 and out_ready=0.
REQ-020 Round-robin mode: grant SHALL be the first valid channel at or after pointer ptr, searching upward and wrapping from NUM-1 to 0.
REQ-021 Round-robin mode: after each transfer from g, ptr SHALL become g+1, wrapping NUM-1 to 0; without a transfer, ptr SHALL hold.
REQ-022 Static mode: grant SHALL be sel when sel < NUM and in_valid[sel]=1; when sel >= NUM, no grant and in_ready SHALL be all zero.
REQ-023 Static mode: ptr SHALL hold its value; switching mode SHALL take effect in the same cycle, with no flush of the output register.
REQ-024 With no valid input, or ld=0, in_ready SHALL be all zero and the output register SHALL not load.
REQ-025 in_ready SHALL be combinational from in_valid, mode, sel, ptr, out_valid and out_ready; no combinational path from in_data to any output.

Reset
REQ-026 When rst=1 at a clock edge, SHALL set out_valid=0, out_data=0, out_idx=0 and ptr=0.
REQ-027 During rst=1, in_ready SHALL be all zero; data held in the output register mid-operation SHALL be discarded.
REQ-028 The first cycle after reset release SHALL operate normally, with ptr=0.

Structure
REQ-029 A shared package rvv_mux_pkg SHALL hold the mode enum (MUX_RR=0, MUX_STATIC=1) and constant MUX_MAX_NUM=16.
REQ-030 Round-robin pick SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: grant index, grant found), purely combinational, parametrised by NUM.
REQ-031 The output register and ptr SHALL live in rr_mux_pipe; only these are sequential state.

Verification
REQ-032 Scenario: NUM=8, RR mode, in_valid=8'hFF held, out_ready=1 -> out_idx sequence 0,1,...,7,0 with out_valid continuously 1 from cycle 1.
REQ-033 Scenario: RR mode, in_valid=8'b1000_0001, ptr=1 -> grant 7, then 0, then 7; each in_ready is one-hot.
REQ-034 Scenario: out_ready=0 for 3 cycles after a load of data 32'hA5A5_0003 from channel 3 -> out_data and out_idx stable, in_ready=0; on release, the next beat loads in the same cycle as the drain.
REQ-035 Scenario: static mode, sel=5, in_valid=8'hFF -> only channel 5 served every cycle; sel=7 with NUM=6 -> in_ready=0 and out_valid falls after drain.
REQ-036 Scenario: rst asserted while out_valid=1 and ptr=4 -> next cycle out_valid=0, out_data=0, out_idx=0, and the next RR grant starts search at 0.

Source files
------------

// File: rtl/rvv_mux_pkg.sv
// Shared types and limits for the round-robin / static output multiplexer.
package rvv_mux_pkg;

  typedef enum logic {
    MUX_RR     = 1'b0,
    MUX_STATIC = 1'b1
  } mux_mode_e;

  localparam int unsigned MUX_MAX_NUM = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter  int unsigned NUM  = 8,
  localparam int unsigned SELW = $clog2(NUM)
) (
  input  logic [NUM-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            found
);

  // One spare bit so ptr + k can exceed NUM-1 before the wrap subtraction.
  localparam logic [SELW:0] NumW = (SELW + 1)'(NUM);

  logic [SELW:0] cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(NUM); k++) begin
      cand = {1'b0, ptr} + (SELW + 1)'(k);
      if (cand >= NumW) begin
        cand = cand - NumW;
      end
      if (!found && req[cand[SELW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_mux_pipe.sv
// N-to-1 multiplexer with round-robin or static selection feeding a single
// full-throughput output register with valid/ready handshakes.
module rr_mux_pipe
  import rvv_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned NUM   = 8,
  localparam int unsigned SELW  = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NUM-1:0]       in_valid,
  input  logic [NUM*WIDTH-1:0] in_data,
  output logic [NUM-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_idx,
  input  logic                 out_ready
);

  localparam int unsigned   PadN    = 2 ** SELW;
  localparam logic [SELW-1:0] LastIdx = SELW'(NUM - 1);

  mux_mode_e       mode_e;
  logic            ld;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_found;
  logic [PadN-1:0] valid_pad;
  logic [SELW-1:0] grant_idx;
  logic            grant_found;
  logic            xfer;

  assign mode_e = mux_mode_e'(mode);
  assign ld     = !out_valid || out_ready;

  // Out-of-range static indices land on zero padding, so they never grant.
  assign valid_pad = PadN'(in_valid);

  rr_pick #(
    .NUM (NUM)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .found   (rr_found)
  );

  always_comb begin
    grant_idx   = rr_idx;
    grant_found = rr_found;
    if (mode_e == MUX_STATIC) begin
      grant_idx   = sel;
      grant_found = valid_pad[sel];
    end
    xfer     = ld && grant_found && !rst;
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
        out_idx   <= grant_idx;
        if (mode_e == MUX_RR) begin
          ptr <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Scoreboard bench for rr_mux_pipe: an 8-channel instance checked cycle by cycle
// against a reference arbiter, plus a 6-channel instance for out-of-range static select.
module tb_rr_mux_pipe;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [2:0]      sel;
  logic [2:0]      sel6;
  logic [7:0]      in_valid;
  logic [8*W-1:0]  in_data;
  logic            out_ready;

  logic [7:0]      in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [2:0]      out_idx;

  logic [5:0]      in_ready6;
  logic            out_valid6;
  logic [W-1:0]    out_data6;
  logic [2:0]      out_idx6;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [2:0]   idx;
    logic [W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    ptr_m = 0;

  always #5 clk = ~clk;

  rr_mux_pipe #(
    .WIDTH (W),
    .NUM   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ready (out_ready)
  );

  rr_mux_pipe #(
    .WIDTH (W),
    .NUM   (6)
  ) dut6 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel6),
    .in_valid  (in_valid[5:0]),
    .in_data   (in_data[6*W-1:0]),
    .in_ready  (in_ready6),
    .out_valid (out_valid6),
    .out_data  (out_data6),
    .out_idx   (out_idx6),
    .out_ready (out_ready)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) begin
      in_data[i*W +: W] = $urandom;
    end
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, advances the model.
  task automatic tick();
    logic [7:0] er;
    bit         ld;
    bit         found;
    int         g;
    beat_t      b;
    @(negedge clk);
    ld    = (sb.size() == 0) || out_ready;
    found = 1'b0;
    g     = 0;
    if (!mode) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && in_valid[(ptr_m + k) % 8]) begin
          found = 1'b1;
          g     = (ptr_m + k) % 8;
        end
      end
    end else if (in_valid[sel]) begin
      found = 1'b1;
      g     = int'(sel);
    end
    er = '0;
    if (!rst && ld && found) er[g] = 1'b1;
    check_val("in_ready", 64'(in_ready), 64'(er));
    check_val("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0 && out_valid) begin
      check_val("out_idx", 64'(out_idx), 64'(sb[0].idx));
      check_val("out_data", 64'(out_data), 64'(sb[0].data));
      if (out_ready) void'(sb.pop_front());
    end
    if (rst) begin
      sb.delete();
      ptr_m = 0;
    end else if (er != 0) begin
      b.idx  = 3'(g);
      b.data = in_data[g*W +: W];
      sb.push_back(b);
      if (!mode) ptr_m = (g + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 3'd0;
    sel6      = 3'd0;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    rand_data();
    @(posedge clk);
    #1;
    tick();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_idx", 64'(out_idx), 64'd0);
    rst = 1'b0;

    // All channels requesting: 0..7 then wrap, one beat per cycle.
    in_valid = 8'hFF;
    repeat (10) begin tick(); rand_data(); end

    // Drain, then set ptr to 1 via a transfer from channel 0.
    in_valid = 8'h00;
    tick();
    in_valid = 8'h01;
    tick();
    in_valid = 8'h81;
    repeat (4) begin tick(); rand_data(); end

    // Backpressure holding a beat from channel 3.
    in_valid = 8'h08;
    in_data[3*W +: W] = 32'hA5A5_0003;
    tick();
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    repeat (3) begin tick(); rand_data(); end
    check_val("hold_data", 64'(out_data), 64'h0000_0000_A5A5_0003);
    check_val("hold_idx", 64'(out_idx), 64'd3);
    out_ready = 1'b1;
    repeat (2) begin tick(); rand_data(); end

    // Static select; the 6-channel instance sits on channel 2 meanwhile.
    mode = 1'b1;
    sel  = 3'd5;
    sel6 = 3'd2;
    repeat (5) begin tick(); rand_data(); end
    check_val("n6_valid", 64'(out_valid6), 64'd1);
    check_val("n6_idx", 64'(out_idx6), 64'd2);
    sel  = 3'd7;
    sel6 = 3'd7;
    #1;
    check_val("n6_ready_oor", 64'(in_ready6), 64'd0);
    tick();
    check_val("n6_valid_drain", 64'(out_valid6), 64'd0);
    tick();

    // Back to round-robin with a beat still in the register.
    mode = 1'b0;
    repeat (7) begin tick(); rand_data(); end
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_data", 64'(out_data), 64'd0);
    check_val("mid_rst_idx", 64'(out_idx), 64'd0);
    out_ready = 1'b1;
    in_valid  = 8'hFF;
    repeat (3) begin tick(); rand_data(); end
    in_valid = 8'h30;
    repeat (3) begin tick(); rand_data(); end
    in_valid = 8'h00;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
